// File: rtl/hazard_pkg.sv
// Shared constants and types for the hazard/forwarding unit.
package hazard_pkg;

    // Forwarding select encodings for one EX-stage operand.
    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_WB      = 2'b01;
    localparam logic [1:0] FWD_MEM     = 2'b10;

    // Stall-reason tracker. Outputs never depend on it; it records why ID is held.
    typedef enum logic [1:0] {
        RUN       = 2'b00,
        LU_BUBBLE = 2'b01,
        SB_WAIT   = 2'b10
    } hazard_state_e;

endpackage

// File: rtl/hazard_forward_unit_if.sv
// Pipeline-side bundle of the hazard/forwarding unit: stage register fields in,
// forwarding selects and stall/flush controls out.
interface hazard_forward_unit_if #(
    parameter int NUM_SRC = 2,
    parameter int AW      = 5,
    parameter int CNT_W   = 16
);
    logic                    id_valid;
    logic [NUM_SRC*AW-1:0]   id_rs;
    logic [AW-1:0]           id_rd;
    logic                    id_reg_write;
    logic [NUM_SRC*AW-1:0]   ex_rs;
    logic [AW-1:0]           ex_rd;
    logic                    ex_reg_write;
    logic                    ex_mem_read;
    logic                    ex_mdu_start;
    logic [AW-1:0]           mem_rd;
    logic                    mem_reg_write;
    logic [AW-1:0]           wb_rd;
    logic                    wb_reg_write;
    logic                    mdu_done;
    logic [AW-1:0]           mdu_rd;
    logic                    cnt_clr;
    logic [NUM_SRC*2-1:0]    fwd_sel;
    logic                    stall_if_id;
    logic                    flush_id_ex;
    logic [CNT_W-1:0]        stall_cnt;
    logic                    hazard_err;

    // Pipeline side: presents stage contents, consumes the controls.
    modport master (
        output id_valid, id_rs, id_rd, id_reg_write,
        output ex_rs, ex_rd, ex_reg_write, ex_mem_read, ex_mdu_start,
        output mem_rd, mem_reg_write, wb_rd, wb_reg_write,
        output mdu_done, mdu_rd, cnt_clr,
        input  fwd_sel, stall_if_id, flush_id_ex, stall_cnt, hazard_err
    );

    // Hazard unit side.
    modport slave (
        input  id_valid, id_rs, id_rd, id_reg_write,
        input  ex_rs, ex_rd, ex_reg_write, ex_mem_read, ex_mdu_start,
        input  mem_rd, mem_reg_write, wb_rd, wb_reg_write,
        input  mdu_done, mdu_rd, cnt_clr,
        output fwd_sel, stall_if_id, flush_id_ex, stall_cnt, hazard_err
    );
endinterface

// File: rtl/reg_scoreboard.sv
// One busy bit per architectural register for results pending in the MDU.
// Register 0 is hardwired not-busy; a same-cycle set and clear of one register
// leaves it busy.
module reg_scoreboard #(
    parameter int AW      = 5,
    parameter int NUM_SRC = 2
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  set_en,
    input  logic [AW-1:0]         set_addr,
    input  logic                  clr_en,
    input  logic [AW-1:0]         clr_addr,
    input  logic [NUM_SRC*AW-1:0] rs_addr,
    output logic [NUM_SRC-1:0]    rs_busy,
    input  logic [AW-1:0]         waw_addr,
    output logic                  waw_busy
);

    logic [2**AW-1:0] busy;

    // Busy-bit update: clear first, then set, so set wins on a collision.
    // NOTE: the busy bits are ordinary flops, not RAM, and must start all clear,
    // so the whole vector is reset; a stale bit would stall ID forever.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            busy <= '0;
        end else begin
            // NOTE: non-blocking updates; the later set overrides the earlier clear.
            if (clr_en) begin
                busy[clr_addr] <= 1'b0;
            end
            if (set_en && (set_addr != '0)) begin
                busy[set_addr] <= 1'b1;
            end
        end
    end

    // Source lookups read the registered bits only.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_lookup
        assign rs_busy[i] = busy[rs_addr[i*AW +: AW]];
    end

    assign waw_busy = busy[waw_addr];

endmodule

// File: rtl/hazard_forward_unit.sv
// EX-stage operand forwarding plus ID-stage load-use and MDU scoreboard hazard
// detection, with stall statistics and a sticky stall-timeout flag.
module hazard_forward_unit
    import hazard_pkg::*;
#(
    parameter int NUM_SRC       = 2,
    parameter int AW            = 5,
    parameter int CNT_W         = 16,
    parameter int STALL_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  arst,
    hazard_forward_unit_if.slave  bus
);

    localparam int RUN_W = $clog2(STALL_TIMEOUT + 1);

    logic [NUM_SRC*2-1:0] fwd_sel;
    logic                 lu_match;
    logic                 lu_hazard;
    logic [NUM_SRC-1:0]   rs_busy;
    logic                 waw_busy;
    logic                 sb_hazard;
    logic                 stall;
    hazard_state_e        state_q;
    hazard_state_e        state_d;
    logic [CNT_W-1:0]     stall_cnt_q;
    logic [RUN_W-1:0]     run_cnt_q;
    logic                 hazard_err_q;
    logic                 unused_ok;

    // ID/EX regwrite does not feed any hazard decision in this unit.
    assign unused_ok = &{1'b0, bus.ex_reg_write};

    // Per-operand forwarding select; EX/MEM beats MEM/WB, x0 never forwards.
    always_comb begin
        // NOTE: default first so every path assigns every bit; no latch.
        fwd_sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (bus.mem_reg_write && (bus.mem_rd != '0) &&
                (bus.mem_rd == bus.ex_rs[i*AW +: AW])) begin
                fwd_sel[i*2 +: 2] = FWD_MEM;
            end else if (bus.wb_reg_write && (bus.wb_rd != '0) &&
                         (bus.wb_rd == bus.ex_rs[i*AW +: AW])) begin
                fwd_sel[i*2 +: 2] = FWD_WB;
            end else begin
                fwd_sel[i*2 +: 2] = FWD_REGFILE;
            end
        end
    end

    // Load-use: a load in EX whose destination any ID source reads.
    always_comb begin
        lu_match = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (bus.id_rs[i*AW +: AW] == bus.ex_rd) begin
                lu_match = 1'b1;
            end
        end
    end

    assign lu_hazard = bus.id_valid && bus.ex_mem_read && (bus.ex_rd != '0) && lu_match;

    reg_scoreboard #(
        .AW      (AW),
        .NUM_SRC (NUM_SRC)
    ) u_scoreboard (
        .clk      (clk),
        .arst     (arst),
        .set_en   (bus.ex_mdu_start),
        .set_addr (bus.ex_rd),
        .clr_en   (bus.mdu_done),
        .clr_addr (bus.mdu_rd),
        .rs_addr  (bus.id_rs),
        .rs_busy  (rs_busy),
        .waw_addr (bus.id_rd),
        .waw_busy (waw_busy)
    );

    assign sb_hazard = bus.id_valid && ((|rs_busy) || (bus.id_reg_write && waw_busy));
    assign stall     = lu_hazard || sb_hazard;

    assign bus.fwd_sel     = fwd_sel;
    assign bus.stall_if_id = stall;
    assign bus.flush_id_ex = stall;
    assign bus.stall_cnt   = stall_cnt_q;
    assign bus.hazard_err  = hazard_err_q;

    // Stall-reason state register.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Stall-reason next state; scoreboard waits take precedence over load-use.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (sb_hazard) begin
                    state_d = SB_WAIT;
                end else if (lu_hazard) begin
                    state_d = LU_BUBBLE;
                end
            end
            LU_BUBBLE: begin
                state_d = sb_hazard ? SB_WAIT : RUN;
            end
            SB_WAIT: begin
                if (!sb_hazard) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Saturating stall total, consecutive-stall run length and sticky timeout.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            stall_cnt_q  <= '0;
            run_cnt_q    <= '0;
            hazard_err_q <= 1'b0;
        end else if (bus.cnt_clr) begin
            stall_cnt_q  <= '0;
            run_cnt_q    <= '0;
            hazard_err_q <= 1'b0;
        end else if (stall) begin
            if (stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            // The run length stops at the timeout; the flag is already set by then.
            if (run_cnt_q != RUN_W'(STALL_TIMEOUT)) begin
                run_cnt_q <= run_cnt_q + 1'b1;
            end
            if (run_cnt_q == RUN_W'(STALL_TIMEOUT - 1)) begin
                hazard_err_q <= 1'b1;
            end
        end else begin
            run_cnt_q <= '0;
        end
    end

endmodule
